// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - instruction cache two-word line refill controller
//
// On a cache miss, fetches the two 32-bit words of the aligned 8-byte line.
// It then presents the assembled line to the cache with a one-cycle write strobe.
// Every output comes straight from a flop.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   cache_miss   miss flag from the instruction cache
//   miss_addr    fetch address that missed
//   mem_req      read request to instruction memory
//   mem_addr     word-aligned read address
//   mem_ack      mem_rdata is valid this cycle
//   mem_rdata    memory read word
//   block        assembled line, word 0 in the low half
//   cache_write  one-cycle line-write strobe
//   refill_busy  high whenever a refill is in progress
//   refill_count saturating count of completed refills
module icache_refill #(
  parameter int LINE_WORDS = 2,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cache_miss,
  input  logic [31:0]             miss_addr,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  input  logic                    mem_ack,
  input  logic [31:0]             mem_rdata,
  output logic [32*LINE_WORDS-1:0] block,
  output logic                    cache_write,
  output logic                    refill_busy,
  output logic [CNT_W-1:0]        refill_count
);

  typedef enum logic [2:0] {IDLE, REQ0, REQ1, WRITE, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             base_q, base_d;
  logic                    mem_req_q, mem_req_d;
  logic [31:0]             mem_addr_q, mem_addr_d;
  logic [32*LINE_WORDS-1:0] block_q, block_d;
  logic                    cache_write_q, cache_write_d;
  logic                    refill_busy_q, refill_busy_d;
  logic [CNT_W-1:0]        count_q, count_d;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    block_d  = block_q;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        if (cache_miss) begin
          // The low three address bits never matter: the line base is used
          // even for a misaligned fetch address.
          base_d  = miss_addr & 32'hFFFF_FFF8;
          state_d = REQ0;
        end
      end
      REQ0: begin
        if (mem_ack) begin
          block_d[31:0] = mem_rdata;
          state_d       = REQ1;
        end
      end
      REQ1: begin
        if (mem_ack) begin
          block_d[63:32] = mem_rdata;
          state_d        = WRITE;
          // The count is bumped as the line is committed, so it is already
          // updated in the cycle where cache_write is high.
          if (count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      WRITE:   state_d = HOLD;
      // The cache is re-evaluating the fetch, so a miss seen here is stale.
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state.
    // That way the registered values line up with the state they describe.
    mem_req_d     = (state_d == REQ0) || (state_d == REQ1);
    cache_write_d = (state_d == WRITE);
    refill_busy_d = (state_d != IDLE);
    if (state_d == REQ0) begin
      mem_addr_d = base_d;
    end else if (state_d == REQ1) begin
      mem_addr_d = base_d + 32'd4;  // wraps modulo 2^32
    end else begin
      mem_addr_d = mem_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      base_q        <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      block_q       <= '0;
      cache_write_q <= 1'b0;
      refill_busy_q <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      block_q       <= block_d;
      cache_write_q <= cache_write_d;
      refill_busy_q <= refill_busy_d;
      count_q       <= count_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign block        = block_q;
  assign cache_write  = cache_write_q;
  assign refill_busy  = refill_busy_q;
  assign refill_count = count_q;

endmodule

// File: doc/icache_refill.md
ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, port name reset.
REQ-002 Parameter LINE_WORDS, default 2, meaning 32-bit words per cache line; only value 2 is supported.
REQ-003 Parameter CNT_W, default 16, meaning width of the refill counter.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 cache_miss  input  1  miss flag from the instruction cache.
REQ-007 miss_addr  input  32  fetch address presented to the cache.
REQ-008 mem_req  output  1  read request to instruction memory.
REQ-009 mem_addr  output  32  word-aligned read address.
REQ-010 mem_ack  input  1  memory has valid mem_rdata this cycle.
REQ-011 mem_rdata  input  32  memory read word.
REQ-012 block  output  64  assembled line to the cache.
REQ-013 cache_write  output  1  one-cycle line-write strobe to the cache.
REQ-014 refill_busy  output  1  high whenever state is not IDLE; fetch stage stalls on it.
REQ-015 refill_count  output  CNT_W  number of completed refills, saturating.

Function
REQ-016 FSM states SHALL be IDLE, REQ0, REQ1, WRITE, HOLD; all outputs registered.
REQ-017 IDLE: cache_miss=1 at an edge SHALL capture line base {miss_addr[31:3],3'b000} and enter REQ0.
REQ-018 miss_addr[1:0] SHALL be ignored; the line base is used regardless of misalignment.
REQ-019 REQ0: mem_req=1, mem_addr=base; mem_ack=1 at an edge SHALL load mem_rdata into block[31:0] and enter REQ1.
REQ-020 REQ1: mem_req=1, mem_addr=base+4; mem_ack=1 at an edge SHALL load mem_rdata into block[63:32] and enter WRITE.
REQ-021 mem_req and mem_addr SHALL stay stable until mem_ack; wait length is unbounded.
REQ-022 mem_req SHALL be deasserted in IDLE, WRITE, HOLD; mem_ack in those states SHALL be ignored with no state change.
REQ-023 WRITE: cache_write=1 for exactly one cycle with block stable; next state HOLD; refill_count increments, saturating at all-ones.
REQ-024 HOLD: cache_write=0, cache_miss ignored (cache is re-evaluating); next state IDLE unconditionally.
REQ-025 block SHALL hold its value after WRITE until overwritten by the next refill.
REQ-026 cache_miss changes while in REQ0/REQ1 SHALL NOT alter the captured base.
REQ-027 Minimum latency: miss sampled edge N -> mem_req high N+1; acks at N+1, N+2 -> cache_write high cycle N+3; IDLE again N+5.
REQ-028 A new miss sampled in IDLE directly after HOLD SHALL start a new refill with no extra gap.
REQ-029 base+4 addition SHALL wrap modulo 2^32 (base 0xFFFF_FFF8 -> 0xFFFF_FFFC; no carry out needed).

Reset
REQ-030 reset=1 at an edge SHALL force IDLE, mem_req=0, mem_addr=0, block=0, cache_write=0, refill_busy=0, refill_count=0.
REQ-031 reset mid-refill SHALL abandon the refill without cache_write; an mem_ack arriving after reset SHALL be ignored.
REQ-032 reset SHALL take priority over cache_miss and mem_ack in the same cycle.

Verification
REQ-033 Back-to-back: miss, miss_addr=0x0000_1234, ack both cycles, rdata 0xAAAA_0001 then 0xBBBB_0002 -> mem_addr 0x1230 then 0x1234, block=0xBBBB_0002_AAAA_0001, one cache_write at cycle N+3, refill_count=1.
REQ-034 Wait states: ack delayed 3 cycles per word -> mem_req/mem_addr stable throughout, cache_write exactly once, refill_busy high from N+1 until HOLD ends.
REQ-035 Reset in REQ1 after first ack, then stray ack -> no cache_write, state IDLE, block=0, refill_count unchanged at 0.
REQ-036 Spurious mem_ack=1 in IDLE and HOLD -> no state change, block unchanged.
REQ-037 Wrap: miss_addr=0xFFFF_FFFE -> mem_addr 0xFFFF_FFF8 then 0xFFFF_FFFC.
REQ-038 Saturation with CNT_W=2: five refills -> refill_count 1,2,3,3,3.
